// File: rtl/lsu_ctrl_pkg.sv
// Shared constants for the load/store unit: op codes, FSM states,
// and small helpers for size, alignment, byte enables and lane data.
package lsu_ctrl_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_BAD = 2'd3
    } size_e;

    function automatic size_e load_size(input logic [2:0] lt);
        size_e sz;
        case (lt)
            LT_LB, LT_LBU: sz = SZ_B;
            LT_LH, LT_LHU: sz = SZ_H;
            LT_LW:         sz = SZ_W;
            default:       sz = SZ_BAD;
        endcase
        return sz;
    endfunction

    function automatic size_e store_size(input logic [1:0] st);
        size_e sz;
        case (st)
            ST_SB:   sz = SZ_B;
            ST_SH:   sz = SZ_H;
            ST_SW:   sz = SZ_W;
            default: sz = SZ_BAD;
        endcase
        return sz;
    endfunction

    // Unknown codes are never aligned so they finish as misaligned errors.
    function automatic logic aligned(input size_e sz, input logic [1:0] off);
        logic ok;
        case (sz)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~off[0];
            SZ_W:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input size_e sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_extend.sv
// Load result formatter: picks the byte/half from the aligned word
// and sign- or zero-extends it according to the load type.
module load_extend
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  ltype,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = word[{offset, 3'b000} +: 8];
    assign h = offset[1] ? word[31:16] : word[15:0];

    // Extension select; unknown types yield zero.
    always_comb begin
        result = '0;
        case (ltype)
            LT_LB:   result = {{24{b[7]}}, b};
            LT_LBU:  result = {24'd0, b};
            LT_LH:   result = {{16{h[15]}}, h};
            LT_LHU:  result = {16'd0, h};
            LT_LW:   result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one pipeline memory op at a time,
// drives a held memory request, and returns a one-cycle response.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_ltype,
    input  logic [1:0]  req_stype,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic        rsp_timeout
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    lsu_state_e  state_q;
    logic [CW-1:0] cnt_q;
    logic        we_q;
    logic [2:0]  ltype_q;
    logic [1:0]  off_q;
    logic [29:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        mis_q;
    logic        to_q;

    size_e       sz_in;
    logic        ok_in;
    logic [3:0]  be_in;
    logic [31:0] wd_in;
    logic [31:0] ext;

    assign sz_in = req_we ? store_size(req_stype) : load_size(req_ltype);
    assign ok_in = aligned(sz_in, req_addr[1:0]);
    assign be_in = req_we ? byte_en(sz_in, req_addr[1:0]) : 4'b1111;
    assign wd_in = req_we ? lane_data(sz_in, req_wdata) : 32'd0;

    // Request capture, memory wait with timeout, single-cycle response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            ltype_q <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        ltype_q <= req_ltype;
                        off_q   <= req_addr[1:0];
                        addr_q  <= req_addr[31:2];
                        be_q    <= be_in;
                        wdata_q <= wd_in;
                        rdata_q <= '0;
                        cnt_q   <= '0;
                        to_q    <= 1'b0;
                        mis_q   <= ~ok_in;
                        state_q <= ok_in ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        rdata_q <= we_q ? 32'd0 : mem_rdata;
                        state_q <= S_RESP;
                    end else if (cnt_q == LAST) begin
                        to_q    <= 1'b1;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    load_extend u_ext (
        .word   (rdata_q),
        .offset (off_q),
        .ltype  (ltype_q),
        .result (ext)
    );

    assign req_ready    = (state_q == S_IDLE);
    assign mem_req      = (state_q == S_WAIT);
    assign mem_we       = mem_req & we_q;
    assign mem_addr     = {addr_q, 2'b00};
    assign mem_be       = be_q;
    assign mem_wdata    = wdata_q;
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_misalign = rsp_valid & mis_q;
    assign rsp_timeout  = rsp_valid & to_q;
    assign rsp_rdata    = (rsp_valid && !we_q && !mis_q && !to_q) ? ext : 32'd0;

endmodule
